// File: rtl/int_exec_pipe.sv
// int_exec_pipe: multi-lane integer execution pipeline.
// Each lane computes ALU / SLT / SEL results and resolves direct (BR) and
// register-indirect (JR) branches. It also flags replay when a used register
// operand is not yet valid. Results travel through EXEC_DEPTH register stages.
// Every stage applies a selective active-list flush. The oldest mispredicting
// output lane is chosen for recovery.
// Ports:
//   clk, rstN            clock, asynchronous active-low reset
//   stall, clear         freeze all stages / kill all in-flight ops
//   flushValid/All/Head/Tail  selective flush of range [head, tail), circular
//   alHead               active-list head, used for age ordering
//   in*                  per-lane op, operands, PC, displacement, prediction
//   out*                 per-lane results from the last stage
//   recover*             oldest mispredicting lane and its target
//   mispredCount         saturating count of cycles with recoverValid high
module int_exec_pipe #(
    parameter int LANES        = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int AL_PTR_WIDTH = 6,
    parameter int EXEC_DEPTH   = 1,
    localparam int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           stall,
    input  logic                           clear,
    input  logic                           flushValid,
    input  logic                           flushAll,
    input  logic [AL_PTR_WIDTH-1:0]        flushHead,
    input  logic [AL_PTR_WIDTH-1:0]        flushTail,
    input  logic [AL_PTR_WIDTH-1:0]        alHead,
    input  logic [LANES-1:0]               inValid,
    input  logic [LANES*4-1:0]             inOp,
    input  logic [LANES*3-1:0]             inCond,
    input  logic [LANES*DATA_WIDTH-1:0]    inOpA,
    input  logic [LANES*DATA_WIDTH-1:0]    inOpB,
    input  logic [LANES-1:0]               inOpAValid,
    input  logic [LANES-1:0]               inOpBValid,
    input  logic [LANES-1:0]               inUseA,
    input  logic [LANES-1:0]               inUseB,
    input  logic [LANES*ADDR_WIDTH-1:0]    inPc,
    input  logic [LANES*DATA_WIDTH-1:0]    inDisp,
    input  logic [LANES-1:0]               inPredTaken,
    input  logic [LANES*ADDR_WIDTH-1:0]    inPredAddr,
    input  logic [LANES*AL_PTR_WIDTH-1:0]  inAlPtr,
    output logic [LANES-1:0]               outValid,
    output logic [LANES*DATA_WIDTH-1:0]    outData,
    output logic [LANES-1:0]               outReplay,
    output logic [LANES-1:0]               outBrValid,
    output logic [LANES-1:0]               outBrTaken,
    output logic [LANES*ADDR_WIDTH-1:0]    outBrTarget,
    output logic [LANES-1:0]               outMispred,
    output logic [LANES*AL_PTR_WIDTH-1:0]  outAlPtr,
    output logic                           recoverValid,
    output logic [LANE_W-1:0]              recoverLane,
    output logic [ADDR_WIDTH-1:0]          recoverTarget,
    output logic [15:0]                    mispredCount
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd8;
    localparam logic [3:0] OP_JR   = 4'd9;
    localparam logic [3:0] OP_SEL  = 4'd10;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef struct packed {
        logic                    valid;
        logic [DATA_WIDTH-1:0]   data;
        logic                    replay;
        logic                    br_valid;
        logic                    br_taken;
        logic [ADDR_WIDTH-1:0]   br_target;
        logic                    mispred;
        logic [AL_PTR_WIDTH-1:0] al_ptr;
    } entry_t;

    entry_t in_s    [LANES];
    entry_t feed_s  [EXEC_DEPTH][LANES];
    entry_t stage_d [EXEC_DEPTH][LANES];
    entry_t stage_q [EXEC_DEPTH][LANES];
    logic [15:0] mispred_cnt_d;
    logic [15:0] mispred_cnt_q;

    function automatic logic cond_eval(input logic [2:0] cond,
                                       input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
        logic r;
        case (cond)
            3'd0:    r = (a == b);
            3'd1:    r = (a != b);
            3'd2:    r = ($signed(a) < $signed(b));
            3'd3:    r = (a < b);
            3'd4:    r = ($signed(a) >= $signed(b));
            3'd5:    r = (a >= b);
            3'd6:    r = 1'b1;
            3'd7:    r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Distance from head is compared against the range length. An empty range
    // (head == tail) therefore hits nothing unless flushAll is set.
    function automatic logic flush_hit(input logic [AL_PTR_WIDTH-1:0] ptr);
        logic [AL_PTR_WIDTH-1:0] off;
        logic [AL_PTR_WIDTH-1:0] span;
        off  = ptr - flushHead;
        span = flushTail - flushHead;
        return flushValid & (flushAll | (off < span));
    endfunction

    // Per-lane compute on the incoming operands.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            logic [DATA_WIDTH-1:0] a_v;
            logic [DATA_WIDTH-1:0] b_v;
            logic [DATA_WIDTH-1:0] disp_v;
            logic [ADDR_WIDTH-1:0] pc_v;
            logic [ADDR_WIDTH-1:0] link_v;
            logic [ADDR_WIDTH-1:0] jr_v;
            logic [3:0]            op_v;
            logic                  c_v;
            logic                  is_br_v;
            a_v     = inOpA[l*DATA_WIDTH +: DATA_WIDTH];
            b_v     = inOpB[l*DATA_WIDTH +: DATA_WIDTH];
            disp_v  = inDisp[l*DATA_WIDTH +: DATA_WIDTH];
            pc_v    = inPc[l*ADDR_WIDTH +: ADDR_WIDTH];
            op_v    = inOp[l*4 +: 4];
            c_v     = cond_eval(inCond[l*3 +: 3], a_v, b_v);
            link_v  = pc_v + PC_STEP;
            jr_v    = ADDR_WIDTH'(a_v + disp_v);
            jr_v[0] = 1'b0;
            is_br_v = (op_v == OP_BR) | (op_v == OP_JR);
            in_s[l] = '0;
            in_s[l].valid  = inValid[l];
            in_s[l].al_ptr = inAlPtr[l*AL_PTR_WIDTH +: AL_PTR_WIDTH];
            in_s[l].replay = (inUseA[l] & ~inOpAValid[l]) | (inUseB[l] & ~inOpBValid[l]);
            case (op_v)
                OP_ADD:  in_s[l].data = a_v + b_v;
                OP_SUB:  in_s[l].data = a_v - b_v;
                OP_AND:  in_s[l].data = a_v & b_v;
                OP_OR:   in_s[l].data = a_v | b_v;
                OP_XOR:  in_s[l].data = a_v ^ b_v;
                OP_SLT:  in_s[l].data = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_v) < $signed(b_v))};
                OP_SLTU: in_s[l].data = {{(DATA_WIDTH-1){1'b0}}, (a_v < b_v)};
                OP_BR:   in_s[l].data = DATA_WIDTH'(link_v);
                OP_JR:   in_s[l].data = DATA_WIDTH'(link_v);
                OP_SEL:  in_s[l].data = c_v ? a_v : b_v;
                default: in_s[l].data = '0;
            endcase
            if (op_v == OP_BR) begin
                in_s[l].br_taken  = c_v;
                in_s[l].br_target = c_v ? (pc_v + ADDR_WIDTH'(disp_v)) : link_v;
            end else if (op_v == OP_JR) begin
                in_s[l].br_taken  = 1'b1;
                in_s[l].br_target = jr_v;
            end else begin
                in_s[l].br_taken  = 1'b0;
                in_s[l].br_target = link_v;
            end
            in_s[l].br_valid = inValid[l] & is_br_v & ~in_s[l].replay;
            in_s[l].mispred  = in_s[l].br_valid &
                ((inPredTaken[l] != in_s[l].br_taken) |
                 (in_s[l].br_taken & (inPredAddr[l*ADDR_WIDTH +: ADDR_WIDTH] != in_s[l].br_target)));
        end
    end

    for (genvar k = 0; k < EXEC_DEPTH; k++) begin : g_feed
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            if (k == 0) begin : g_first
                assign feed_s[k][l] = in_s[l];
            end else begin : g_next
                assign feed_s[k][l] = stage_q[k-1][l];
            end
        end
    end

    // Stage next-state: clear beats stall, stall holds with in-place flush, else advance.
    always_comb begin
        for (int k = 0; k < EXEC_DEPTH; k++) begin
            for (int l = 0; l < LANES; l++) begin
                stage_d[k][l] = stage_q[k][l];
                if (clear) begin
                    stage_d[k][l].valid = 1'b0;
                end else if (stall) begin
                    stage_d[k][l].valid = stage_q[k][l].valid & ~flush_hit(stage_q[k][l].al_ptr);
                end else begin
                    stage_d[k][l]       = feed_s[k][l];
                    stage_d[k][l].valid = feed_s[k][l].valid & ~flush_hit(feed_s[k][l].al_ptr);
                end
            end
        end
    end

    // Pipeline stage registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < EXEC_DEPTH; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    stage_q[k][l] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < EXEC_DEPTH; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    stage_q[k][l] <= stage_d[k][l];
                end
            end
        end
    end

    // Output drive from the last stage with live flush masking, plus oldest-lane pick.
    always_comb begin
        logic [AL_PTR_WIDTH-1:0] best_age;
        outValid      = '0;
        outData       = '0;
        outReplay     = '0;
        outBrValid    = '0;
        outBrTaken    = '0;
        outBrTarget   = '0;
        outMispred    = '0;
        outAlPtr      = '0;
        recoverValid  = 1'b0;
        recoverLane   = '0;
        recoverTarget = '0;
        best_age      = '0;
        for (int l = 0; l < LANES; l++) begin
            logic                    live_v;
            logic                    mp_v;
            logic [AL_PTR_WIDTH-1:0] age_v;
            live_v = stage_q[EXEC_DEPTH-1][l].valid & ~flush_hit(stage_q[EXEC_DEPTH-1][l].al_ptr);
            mp_v   = live_v & stage_q[EXEC_DEPTH-1][l].mispred;
            age_v  = stage_q[EXEC_DEPTH-1][l].al_ptr - alHead;
            outValid[l]   = live_v;
            outData[l*DATA_WIDTH +: DATA_WIDTH]       = stage_q[EXEC_DEPTH-1][l].data;
            outReplay[l]  = stage_q[EXEC_DEPTH-1][l].valid & stage_q[EXEC_DEPTH-1][l].replay;
            outBrValid[l] = live_v & stage_q[EXEC_DEPTH-1][l].br_valid;
            outBrTaken[l] = stage_q[EXEC_DEPTH-1][l].br_taken;
            outBrTarget[l*ADDR_WIDTH +: ADDR_WIDTH]   = stage_q[EXEC_DEPTH-1][l].br_target;
            outMispred[l] = mp_v;
            outAlPtr[l*AL_PTR_WIDTH +: AL_PTR_WIDTH]  = stage_q[EXEC_DEPTH-1][l].al_ptr;
            // Strict less-than keeps the lower lane on an age tie.
            if (mp_v && (!recoverValid || (age_v < best_age))) begin
                recoverValid  = 1'b1;
                recoverLane   = LANE_W'(l);
                recoverTarget = stage_q[EXEC_DEPTH-1][l].br_target;
                best_age      = age_v;
            end else begin
                best_age      = best_age;
            end
        end
    end

    // Saturating mispredict-cycle counter next state.
    always_comb begin
        if (recoverValid && (mispred_cnt_q != 16'hFFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Mispredict counter register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mispred_cnt_q <= 16'd0;
        end else begin
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispredCount = mispred_cnt_q;
endmodule

// File: tb/tb_int_exec_pipe.sv
module tb_int_exec_pipe;
    localparam int L = 2;
    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN, stall, clear, flushValid, flushAll;
    logic [5:0] flushHead, flushTail, alHead;
    logic [L-1:0] inValid, inOpAValid, inOpBValid, inUseA, inUseB, inPredTaken;
    logic [L*4-1:0] inOp;
    logic [L*3-1:0] inCond;
    logic [L*32-1:0] inOpA, inOpB, inPc, inDisp, inPredAddr;
    logic [L*6-1:0] inAlPtr;
    logic [L-1:0] outValid, outReplay, outBrValid, outBrTaken, outMispred;
    logic [L*32-1:0] outData, outBrTarget;
    logic [L*6-1:0] outAlPtr;
    logic recoverValid;
    logic [0:0] recoverLane;
    logic [31:0] recoverTarget;
    logic [15:0] mispredCount;

    int_exec_pipe #(.LANES(L), .DATA_WIDTH(32), .ADDR_WIDTH(32), .AL_PTR_WIDTH(6), .EXEC_DEPTH(D)) dut (
        .clk(clk), .rstN(rstN), .stall(stall), .clear(clear),
        .flushValid(flushValid), .flushAll(flushAll), .flushHead(flushHead), .flushTail(flushTail),
        .alHead(alHead), .inValid(inValid), .inOp(inOp), .inCond(inCond),
        .inOpA(inOpA), .inOpB(inOpB), .inOpAValid(inOpAValid), .inOpBValid(inOpBValid),
        .inUseA(inUseA), .inUseB(inUseB), .inPc(inPc), .inDisp(inDisp),
        .inPredTaken(inPredTaken), .inPredAddr(inPredAddr), .inAlPtr(inAlPtr),
        .outValid(outValid), .outData(outData), .outReplay(outReplay),
        .outBrValid(outBrValid), .outBrTaken(outBrTaken), .outBrTarget(outBrTarget),
        .outMispred(outMispred), .outAlPtr(outAlPtr), .recoverValid(recoverValid),
        .recoverLane(recoverLane), .recoverTarget(recoverTarget), .mispredCount(mispredCount)
    );

    typedef struct {
        bit          v;
        logic [31:0] data;
        bit          rep;
        bit          brv;
        bit          tk;
        logic [31:0] tgt;
        bit          mp;
        logic [5:0]  ptr;
    } m_t;

    m_t pipe [D][L];
    int cnt_model;
    int n_assert = 0;
    int n_fail = 0;
    bit do_check = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fhit(input logic [5:0] p);
        int off, span;
        off  = (int'(p) - int'(flushHead) + 64) % 64;
        span = (int'(flushTail) - int'(flushHead) + 64) % 64;
        return flushValid && (flushAll || (off < span));
    endfunction

    function automatic bit cnd(input int c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            0: return a == b;
            1: return a != b;
            2: return $signed(a) < $signed(b);
            3: return a < b;
            4: return $signed(a) >= $signed(b);
            5: return a >= b;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected result of the op currently presented on lane l.
    function automatic m_t ref_lane(input int l);
        m_t m;
        logic [31:0] a, b, pc, disp;
        int op;
        bit c, isbr;
        a = inOpA[l*32 +: 32];
        b = inOpB[l*32 +: 32];
        pc = inPc[l*32 +: 32];
        disp = inDisp[l*32 +: 32];
        op = int'(inOp[l*4 +: 4]);
        c = cnd(int'(inCond[l*3 +: 3]), a, b);
        case (op)
            0: m.data = a + b;
            1: m.data = a - b;
            2: m.data = a & b;
            3: m.data = a | b;
            4: m.data = a ^ b;
            5: m.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: m.data = (a < b) ? 32'd1 : 32'd0;
            8, 9: m.data = pc + 32'd4;
            10: m.data = c ? a : b;
            default: m.data = 32'd0;
        endcase
        isbr = (op == 8) || (op == 9);
        m.tk = (op == 9) ? 1'b1 : ((op == 8) ? c : 1'b0);
        if (op == 9) m.tgt = (a + disp) & 32'hFFFF_FFFE;
        else m.tgt = m.tk ? pc + disp : pc + 32'd4;
        m.v = inValid[l];
        m.ptr = inAlPtr[l*6 +: 6];
        m.rep = (inUseA[l] && !inOpAValid[l]) || (inUseB[l] && !inOpBValid[l]);
        m.brv = m.v && isbr && !m.rep;
        m.mp = m.brv && ((inPredTaken[l] != m.tk) || (m.tk && inPredAddr[l*32 +: 32] != m.tgt));
        return m;
    endfunction

    task automatic exp_rec(output bit rv, output int lane, output logic [31:0] tgt);
        int best = 1000;
        rv = 1'b0; lane = 0; tgt = 32'd0;
        for (int l = 0; l < L; l++) begin
            m_t m = pipe[D-1][l];
            if (m.v && !fhit(m.ptr) && m.mp) begin
                int age = (int'(m.ptr) - int'(alHead) + 64) % 64;
                if (age < best) begin best = age; rv = 1'b1; lane = l; tgt = m.tgt; end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < D; k++)
            for (int l = 0; l < L; l++) pipe[k][l] = '{default: 0};
        cnt_model = 0;
    endtask

    task automatic model_edge();
        bit rv; int ln; logic [31:0] tg;
        if (!rstN) begin model_reset(); return; end
        exp_rec(rv, ln, tg);
        if (rv && cnt_model < 65535) cnt_model++;
        if (clear) begin
            for (int k = 0; k < D; k++) for (int l = 0; l < L; l++) pipe[k][l].v = 1'b0;
        end else if (stall) begin
            for (int k = 0; k < D; k++)
                for (int l = 0; l < L; l++) if (fhit(pipe[k][l].ptr)) pipe[k][l].v = 1'b0;
        end else begin
            for (int k = D-1; k >= 1; k--)
                for (int l = 0; l < L; l++) begin
                    pipe[k][l] = pipe[k-1][l];
                    if (fhit(pipe[k][l].ptr)) pipe[k][l].v = 1'b0;
                end
            for (int l = 0; l < L; l++) begin
                pipe[0][l] = ref_lane(l);
                if (fhit(pipe[0][l].ptr)) pipe[0][l].v = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        bit rv; int ln; logic [31:0] tg;
        for (int l = 0; l < L; l++) begin
            m_t m = pipe[D-1][l];
            bit ev = m.v && !fhit(m.ptr);
            bit eb = ev && m.brv;
            chk($sformatf("outValid[%0d]", l), outValid[l], ev);
            if (ev) begin
                chk($sformatf("outData[%0d]", l), outData[l*32 +: 32], m.data);
                chk($sformatf("outAlPtr[%0d]", l), outAlPtr[l*6 +: 6], m.ptr);
            end
            chk($sformatf("outReplay[%0d]", l), outReplay[l], m.v && m.rep);
            chk($sformatf("outBrValid[%0d]", l), outBrValid[l], eb);
            if (eb) begin
                chk($sformatf("outBrTaken[%0d]", l), outBrTaken[l], m.tk);
                chk($sformatf("outBrTarget[%0d]", l), outBrTarget[l*32 +: 32], m.tgt);
            end
            chk($sformatf("outMispred[%0d]", l), outMispred[l], eb && m.mp);
        end
        exp_rec(rv, ln, tg);
        chk("recoverValid", recoverValid, rv);
        chk("recoverLane", recoverLane, ln);
        chk("recoverTarget", recoverTarget, tg);
        chk("mispredCount", mispredCount, cnt_model);
    endtask

    task automatic cyc();
        #1;
        if (do_check) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        inValid = '0; inOp = '0; inCond = '0; inOpA = '0; inOpB = '0;
        inOpAValid = '0; inOpBValid = '0; inUseA = '0; inUseB = '0;
        inPc = '0; inDisp = '0; inPredTaken = '0; inPredAddr = '0; inAlPtr = '0;
        stall = 1'b0; clear = 1'b0; flushValid = 1'b0; flushAll = 1'b0;
        flushHead = 6'd0; flushTail = 6'd0;
    endtask

    task automatic set_lane(input int l, input logic [3:0] op, input logic [2:0] c,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                            input logic [31:0] disp, input logic pt, input logic [31:0] pa,
                            input logic [5:0] ptr);
        inValid[l] = 1'b1; inOp[l*4 +: 4] = op; inCond[l*3 +: 3] = c;
        inOpA[l*32 +: 32] = a; inOpB[l*32 +: 32] = b;
        inOpAValid[l] = 1'b1; inOpBValid[l] = 1'b1; inUseA[l] = 1'b1; inUseB[l] = 1'b1;
        inPc[l*32 +: 32] = pc; inDisp[l*32 +: 32] = disp;
        inPredTaken[l] = pt; inPredAddr[l*32 +: 32] = pa; inAlPtr[l*6 +: 6] = ptr;
    endtask

    task automatic rand_inputs();
        int ops [12] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 7, 15};
        for (int l = 0; l < L; l++) begin
            logic [31:0] pc, disp;
            pc = $urandom & 32'hFFFF_FFFC;
            disp = 32'($urandom_range(0, 255)) - 32'd128;
            inValid[l] = ($urandom_range(0, 3) != 0);
            inOp[l*4 +: 4] = 4'(ops[$urandom_range(0, 11)]);
            inCond[l*3 +: 3] = 3'($urandom_range(0, 7));
            inOpA[l*32 +: 32] = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            inOpB[l*32 +: 32] = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            inOpAValid[l] = ($urandom_range(0, 7) != 0);
            inOpBValid[l] = ($urandom_range(0, 7) != 0);
            inUseA[l] = 1'($urandom_range(0, 1));
            inUseB[l] = 1'($urandom_range(0, 1));
            inPc[l*32 +: 32] = pc;
            inDisp[l*32 +: 32] = disp;
            inPredTaken[l] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: inPredAddr[l*32 +: 32] = pc + 32'd4;
                1: inPredAddr[l*32 +: 32] = pc + disp;
                default: inPredAddr[l*32 +: 32] = $urandom;
            endcase
            inAlPtr[l*6 +: 6] = 6'($urandom_range(0, 63));
        end
        stall = ($urandom_range(0, 7) == 0);
        clear = ($urandom_range(0, 31) == 0);
        flushValid = ($urandom_range(0, 5) == 0);
        flushAll = ($urandom_range(0, 3) == 0);
        flushHead = 6'($urandom_range(0, 63));
        flushTail = 6'($urandom_range(0, 63));
        alHead = 6'($urandom_range(0, 63));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outValid"}, outValid, 0);
        chk({tag, "_outData"}, outData, 0);
        chk({tag, "_outReplay"}, outReplay, 0);
        chk({tag, "_outBrValid"}, outBrValid, 0);
        chk({tag, "_outBrTaken"}, outBrTaken, 0);
        chk({tag, "_outBrTarget"}, outBrTarget, 0);
        chk({tag, "_outMispred"}, outMispred, 0);
        chk({tag, "_outAlPtr"}, outAlPtr, 0);
        chk({tag, "_recoverValid"}, recoverValid, 0);
        chk({tag, "_recoverLane"}, recoverLane, 0);
        chk({tag, "_recoverTarget"}, recoverTarget, 0);
        chk({tag, "_mispredCount"}, mispredCount, 0);
    endtask

    initial begin
        rstN = 1'b0; alHead = 6'd0; idle(); model_reset();
        #2;
        chk_all_zero("reset");
        cyc(); cyc();
        rstN = 1'b1;
        cyc();

        // ADD wrap and signed/unsigned compare, two-cycle latency.
        set_lane(0, 4'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b0, 32'h0, 6'd1);
        set_lane(1, 4'd5, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b0, 32'h0, 6'd2);
        cyc(); idle();
        #1 chk("lat_outValid_early", outValid, 2'b00);
        cyc();
        chk("add_outValid", outValid, 2'b11);
        chk("add_wrap", outData[31:0], 32'd0);
        chk("slt_signed", outData[63:32], 32'd1);
        set_lane(1, 4'd6, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b0, 32'h0, 6'd2);
        cyc(); idle(); cyc();
        chk("sltu_unsigned", outData[63:32], 32'd0);

        // BR EQ taken and mispredicted; JR correctly predicted.
        set_lane(0, 4'd8, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0, 6'd0);
        set_lane(1, 4'd9, 3'd6, 32'h203, 32'd0, 32'h300, 32'h0, 1'b1, 32'h202, 6'd0);
        cyc(); idle(); cyc();
        chk("br_taken", outBrTaken[0], 1'b1);
        chk("br_target", outBrTarget[31:0], 32'h120);
        chk("br_mispred", outMispred[0], 1'b1);
        chk("br_recoverValid", recoverValid, 1'b1);
        chk("br_recoverTarget", recoverTarget, 32'h120);
        chk("jr_target", outBrTarget[63:32], 32'h202);
        chk("jr_mispred", outMispred[1], 1'b0);

        // Replay suppresses branch resolution.
        set_lane(0, 4'd8, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0, 6'd0);
        inOpAValid[0] = 1'b0;
        cyc(); idle(); cyc();
        chk("replay_out", outReplay[0], 1'b1);
        chk("replay_brValid", outBrValid[0], 1'b0);
        chk("replay_mispred", outMispred[0], 1'b0);
        chk("replay_recoverValid", recoverValid, 1'b0);

        // Wrapping range flush [0x3E, 0x02) across both stages.
        set_lane(0, 4'd0, 3'd0, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 32'h0, 6'h3F);
        set_lane(1, 4'd0, 3'd0, 32'd2, 32'd2, 32'h0, 32'h0, 1'b0, 32'h0, 6'h02);
        cyc();
        inAlPtr[5:0] = 6'h01;
        cyc(); idle();
        flushValid = 1'b1; flushHead = 6'h3E; flushTail = 6'h02;
        #1 chk("flush_live_mask", outValid, 2'b10);
        cyc(); idle();
        #1 chk("flush_stage0_kill", outValid, 2'b10);

        // Same flush while stalled.
        set_lane(0, 4'd0, 3'd0, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 32'h0, 6'h3F);
        set_lane(1, 4'd0, 3'd0, 32'd2, 32'd2, 32'h0, 32'h0, 1'b0, 32'h0, 6'h02);
        cyc();
        inAlPtr[5:0] = 6'h01;
        cyc(); idle();
        stall = 1'b1; flushValid = 1'b1; flushHead = 6'h3E; flushTail = 6'h02;
        cyc(); idle(); stall = 1'b1;
        #1 chk("stall_flush_s1", outValid, 2'b10);
        cyc(); idle();
        #1 chk("stall_flush_s0", outValid, 2'b10);
        cyc();

        // Age ordering for recovery.
        alHead = 6'h3C;
        set_lane(0, 4'd8, 3'd6, 32'd0, 32'd0, 32'h100, 32'h10, 1'b0, 32'h0, 6'h01);
        set_lane(1, 4'd8, 3'd6, 32'd0, 32'd0, 32'h200, 32'h8, 1'b0, 32'h0, 6'h3D);
        cyc(); idle(); cyc();
        chk("age_recoverLane", recoverLane, 1'b1);
        chk("age_recoverTarget", recoverTarget, 32'h208);
        set_lane(0, 4'd8, 3'd6, 32'd0, 32'd0, 32'h100, 32'h10, 1'b0, 32'h0, 6'h05);
        set_lane(1, 4'd8, 3'd6, 32'd0, 32'd0, 32'h200, 32'h8, 1'b0, 32'h0, 6'h05);
        cyc(); idle(); cyc();
        chk("tie_recoverLane", recoverLane, 1'b0);
        chk("tie_recoverTarget", recoverTarget, 32'h110);

        // Randomized traffic against the reference model.
        repeat (1500) begin
            rand_inputs();
            cyc();
        end
        idle(); cyc(); cyc(); cyc();

        // Mispredict every cycle until the counter saturates.
        set_lane(0, 4'd8, 3'd6, 32'd0, 32'd0, 32'h100, 32'h10, 1'b0, 32'h0, 6'h00);
        do_check = 1'b0;
        repeat (70000) cyc();
        do_check = 1'b1;
        cyc();
        chk("mispredCount_sat", mispredCount, 16'hFFFF);

        // Reset mid-stream: outputs zero at once, nothing stale afterwards.
        rstN = 1'b0;
        model_reset();
        #1 chk_all_zero("midreset");
        cyc();
        idle(); rstN = 1'b1;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
